// File: rtl/bullet_resolver.sv
// Bullet/tank hit resolver: scores hits once per frame, enforces post-hit immunity,
// holds the shooter's bullet for two frames, and ends the round at WIN_SCORE.
module bullet_resolver #(
  parameter logic [3:0] WIN_SCORE  = 4'd5,
  parameter logic [7:0] INV_FRAMES = 8'd60,
  parameter logic [9:0] TANK_W     = 10'd32,
  parameter logic [9:0] BULLET_W   = 10'd8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       restart,
  input  logic [9:0] p0_tank_X,
  input  logic [9:0] p0_tank_Y,
  input  logic [9:0] p1_tank_X,
  input  logic [9:0] p1_tank_Y,
  input  logic [9:0] p0_bullet_X,
  input  logic [9:0] p0_bullet_Y,
  input  logic [9:0] p1_bullet_X,
  input  logic [9:0] p1_bullet_Y,
  input  logic [1:0] p0_hit,
  input  logic [1:0] p1_hit,
  output logic [1:0] p0_bull_hit,
  output logic [1:0] p1_bull_hit,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       freeze
);

  typedef enum logic [1:0] {StIdle, StCheck, StHold, StOver} state_e;

  state_e      state_q, state_d;
  logic        fc_sync_q, fc_sync_d, fc_dly_q, fc_dly_d, primed_q, fe_q, fe_d;
  logic        hold_fe_q, hold_fe_d;
  logic [3:0]  score0_q, score0_d, score1_q, score1_d;
  logic [1:0]  winner_q, winner_d, b0_q, b0_d, b1_q, b1_d;
  logic        game_over_q, game_over_d, freeze_q, freeze_d;
  logic [7:0]  imm0_q, imm0_d, imm1_q, imm1_d;
  logic        hit0, hit1, win0, win1;
  logic [3:0]  score0_n, score1_n;

  function automatic logic overlap(input logic [9:0] bx, input logic [9:0] by,
                                   input logic [9:0] tx, input logic [9:0] ty);
    logic [10:0] bx_e, by_e, tx_e, ty_e;
    bx_e = {1'b0, bx};
    by_e = {1'b0, by};
    tx_e = {1'b0, tx};
    ty_e = {1'b0, ty};
    overlap = (bx_e + {1'b0, BULLET_W} > tx_e) && (bx_e < tx_e + {1'b0, TANK_W}) &&
              (by_e + {1'b0, BULLET_W} > ty_e) && (by_e < ty_e + {1'b0, TANK_W});
  endfunction

  // Each bullet is only ever tested against the opposing tank.
  assign hit0 = (p0_hit == 2'b01) && ((p0_bullet_X != 10'd0) || (p0_bullet_Y != 10'd0)) &&
                overlap(p0_bullet_X, p0_bullet_Y, p1_tank_X, p1_tank_Y) && (imm1_q == 8'd0);
  assign hit1 = (p1_hit == 2'b01) && ((p1_bullet_X != 10'd0) || (p1_bullet_Y != 10'd0)) &&
                overlap(p1_bullet_X, p1_bullet_Y, p0_tank_X, p0_tank_Y) && (imm0_q == 8'd0);

  assign score0_n = !hit0 ? score0_q : (score0_q == 4'hF) ? 4'hF : score0_q + 4'd1;
  assign score1_n = !hit1 ? score1_q : (score1_q == 4'hF) ? 4'hF : score1_q + 4'd1;
  assign win0     = hit0 && (score0_n == WIN_SCORE);
  assign win1     = hit1 && (score1_n == WIN_SCORE);

  always_comb begin
    state_d     = state_q;
    hold_fe_d   = hold_fe_q;
    score0_d    = score0_q;
    score1_d    = score1_q;
    winner_d    = winner_q;
    game_over_d = game_over_q;
    freeze_d    = freeze_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    imm0_d      = imm0_q;
    imm1_d      = imm1_q;
    // First cycle after reset seeds both samples so a level already high is not an edge.
    fc_sync_d   = frame_clk;
    fc_dly_d    = primed_q ? fc_sync_q : frame_clk;
    fe_d        = primed_q & fc_sync_q & ~fc_dly_q;

    if (fe_q && (state_q == StIdle || state_q == StHold)) begin
      if (imm0_q != 8'd0) imm0_d = imm0_q - 8'd1;
      if (imm1_q != 8'd0) imm1_d = imm1_q - 8'd1;
    end

    unique case (state_q)
      StIdle: if (fe_q) state_d = StCheck;
      StCheck: begin
        score0_d = score0_n;
        score1_d = score1_n;
        if (hit0) begin
          b0_d   = 2'b00;
          imm1_d = INV_FRAMES;
        end
        if (hit1) begin
          b1_d   = 2'b00;
          imm0_d = INV_FRAMES;
        end
        if (win0 || win1) begin
          state_d     = StOver;
          winner_d    = {win1, win0};
          game_over_d = 1'b1;
          freeze_d    = 1'b1;
          b0_d        = 2'b00;
          b1_d        = 2'b00;
        end else if (hit0 || hit1) begin
          state_d   = StHold;
          hold_fe_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StHold: begin
        if (fe_q) begin
          if (hold_fe_q) begin
            state_d   = StIdle;
            hold_fe_d = 1'b0;
            b0_d      = 2'b01;
            b1_d      = 2'b01;
          end else begin
            hold_fe_d = 1'b1;
          end
        end
      end
      StOver: begin
        if (restart) begin
          state_d     = StIdle;
          score0_d    = 4'd0;
          score1_d    = 4'd0;
          winner_d    = 2'b00;
          game_over_d = 1'b0;
          freeze_d    = 1'b0;
          b0_d        = 2'b01;
          b1_d        = 2'b01;
          imm0_d      = 8'd0;
          imm1_d      = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      fc_sync_q   <= 1'b0;
      fc_dly_q    <= 1'b0;
      primed_q    <= 1'b0;
      fe_q        <= 1'b0;
      hold_fe_q   <= 1'b0;
      score0_q    <= 4'd0;
      score1_q    <= 4'd0;
      winner_q    <= 2'b00;
      game_over_q <= 1'b0;
      freeze_q    <= 1'b0;
      b0_q        <= 2'b01;
      b1_q        <= 2'b01;
      imm0_q      <= 8'd0;
      imm1_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      fc_sync_q   <= fc_sync_d;
      fc_dly_q    <= fc_dly_d;
      primed_q    <= 1'b1;
      fe_q        <= fe_d;
      hold_fe_q   <= hold_fe_d;
      score0_q    <= score0_d;
      score1_q    <= score1_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      freeze_q    <= freeze_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      imm0_q      <= imm0_d;
      imm1_q      <= imm1_d;
    end
  end

  assign p0_bull_hit = b0_q;
  assign p1_bull_hit = b1_q;
  assign score0      = score0_q;
  assign score1      = score1_q;
  assign winner      = winner_q;
  assign game_over   = game_over_q;
  assign freeze      = freeze_q;

endmodule

// File: tb/tb_bullet_resolver.sv
// Scoreboard bench for bullet_resolver: stimulus queues expected output snapshots,
// a monitor pops and compares them against the DUT away from the active edge.
module tb_bullet_resolver;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] p0_tank_X = 10'd100, p0_tank_Y = 10'd100;
  logic [9:0] p1_tank_X = 10'd0, p1_tank_Y = 10'd0;
  logic [9:0] p0_bullet_X = 10'd0, p0_bullet_Y = 10'd0;
  logic [9:0] p1_bullet_X = 10'd0, p1_bullet_Y = 10'd0;
  logic [1:0] p0_hit = 2'b00, p1_hit = 2'b00;
  logic [1:0] p0_bull_hit, p1_bull_hit, winner;
  logic [3:0] score0, score1;
  logic       game_over, freeze;

  bullet_resolver dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .restart(restart),
    .p0_tank_X(p0_tank_X), .p0_tank_Y(p0_tank_Y),
    .p1_tank_X(p1_tank_X), .p1_tank_Y(p1_tank_Y),
    .p0_bullet_X(p0_bullet_X), .p0_bullet_Y(p0_bullet_Y),
    .p1_bullet_X(p1_bullet_X), .p1_bullet_Y(p1_bullet_Y),
    .p0_hit(p0_hit), .p1_hit(p1_hit),
    .p0_bull_hit(p0_bull_hit), .p1_bull_hit(p1_bull_hit),
    .score0(score0), .score1(score1), .winner(winner),
    .game_over(game_over), .freeze(freeze)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic stim_done = 1'b0;

  // Monitor: {b0, b1, score0, score1, winner, game_over, freeze}
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      wait (q.size() > 0);
      @(negedge Clk);
      e   = q.pop_front();
      act = {p0_bull_hit, p1_bull_hit, score0, score1, winner, game_over, freeze};
      n_cmp++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got b0=%b b1=%b s0=%0d s1=%0d w=%b go=%b fr=%b, want b0=%b b1=%b s0=%0d s1=%0d w=%b go=%b fr=%b",
                 e.name, act[15:14], act[13:12], act[11:8], act[7:4], act[3:2], act[1], act[0],
                 e.exp[15:14], e.exp[13:12], e.exp[11:8], e.exp[7:4], e.exp[3:2], e.exp[1],
                 e.exp[0]);
      end
    end
  end

  task automatic expect_out(input string name, input logic [1:0] b0, input logic [1:0] b1,
                            input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] w,
                            input logic go, input logic fr);
    exp_t e;
    int   n;
    e.name = name;
    e.exp  = {b0, b1, s0, s1, w, go, fr};
    q.push_back(e);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      #1;
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: monitor did not sample within bound, got pending=%0d want 0", name,
               q.size());
      q.delete();
    end
  endtask

  // One frame: rising frame_clk, then enough cycles for CHECK to finish.
  task automatic frame();
    @(posedge Clk);
    #1 frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_restart();
    @(posedge Clk);
    #1 restart = 1'b1;
    @(posedge Clk);
    #1 restart = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    #1 Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    expect_out("reset", 2'b01, 2'b01, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);

    // Bullet at (0,0) over a tank at (0,0) never counts.
    p0_hit = 2'b01;
    frame();
    expect_out("origin_no_hit", 2'b01, 2'b01, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);

    p1_tank_X = 10'd540; p1_tank_Y = 10'd240;
    p0_bullet_X = 10'd500; p0_bullet_Y = 10'd250;
    frame();
    expect_out("edge_miss", 2'b01, 2'b01, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);

    p0_bullet_X = 10'd535;
    frame();  // fe#0
    expect_out("basic_hit", 2'b00, 2'b01, 4'd1, 4'd0, 2'b00, 1'b0, 1'b0);
    frame();
    expect_out("hold_frame1", 2'b00, 2'b01, 4'd1, 4'd0, 2'b00, 1'b0, 1'b0);
    frame();
    expect_out("hold_release", 2'b01, 2'b01, 4'd1, 4'd0, 2'b00, 1'b0, 1'b0);

    frames(57);  // fe#3..#59 still immune
    expect_out("immune_fe59", 2'b01, 2'b01, 4'd1, 4'd0, 2'b00, 1'b0, 1'b0);
    frame();     // fe#60, 61st frame
    expect_out("immune_expired", 2'b00, 2'b01, 4'd2, 4'd0, 2'b00, 1'b0, 1'b0);
    frames(2);
    expect_out("hold_release2", 2'b01, 2'b01, 4'd2, 4'd0, 2'b00, 1'b0, 1'b0);
    pulse_restart();
    expect_out("restart_in_idle", 2'b01, 2'b01, 4'd2, 4'd0, 2'b00, 1'b0, 1'b0);

    // Simultaneous hits every 60 frames until both reach WIN_SCORE together.
    p1_bullet_X = 10'd110; p1_bullet_Y = 10'd110; p1_hit = 2'b01;
    do_reset();
    frame();
    expect_out("both_hit_1", 2'b00, 2'b00, 4'd1, 4'd1, 2'b00, 1'b0, 1'b0);
    frames(59);
    expect_out("both_immune", 2'b01, 2'b01, 4'd1, 4'd1, 2'b00, 1'b0, 1'b0);
    frame();
    expect_out("both_hit_2", 2'b00, 2'b00, 4'd2, 4'd2, 2'b00, 1'b0, 1'b0);
    frames(120);
    expect_out("both_hit_4", 2'b00, 2'b00, 4'd4, 4'd4, 2'b00, 1'b0, 1'b0);
    frames(60);
    expect_out("draw_over", 2'b00, 2'b00, 4'd5, 4'd5, 2'b11, 1'b1, 1'b1);
    frames(3);
    expect_out("over_ignores", 2'b00, 2'b00, 4'd5, 4'd5, 2'b11, 1'b1, 1'b1);
    pulse_restart();
    expect_out("restart_over", 2'b01, 2'b01, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    frame();
    expect_out("post_restart_hit", 2'b00, 2'b00, 4'd1, 4'd1, 2'b00, 1'b0, 1'b0);

    // Async reset mid-HOLD, checked before the next rising edge.
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    expect_out("async_reset", 2'b01, 2'b01, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);

    // frame_clk already high at release must not produce a CHECK.
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    expect_out("no_phantom_fe", 2'b01, 2'b01, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
    frame_clk = 1'b0;

    stim_done = 1'b1;
    repeat (2) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
